// File: rtl/mem_access_pkg.sv
// Shared types and encodings for the memory-stage access controller.
package mem_access_pkg;
  localparam int MEM_WORDS_DEF = 256;
  localparam logic SIZE_WORD = 1'b0;
  localparam logic SIZE_BYTE = 1'b1;

  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RESP} state_t;
endpackage

// File: rtl/byte_lane_merge.sv
// Combinational byte-lane helper: extracts/extends a lane for loads and inserts
// a byte into a lane for read-modify-write stores. Lanes are little-endian.
module byte_lane_merge #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] word,
  input  logic              lane,
  input  logic              sgn,
  input  logic [7:0]        wbyte,
  output logic [DATA_W-1:0] ext,
  output logic [DATA_W-1:0] merged
);
  logic [7:0] sel;

  assign sel    = lane ? word[15:8] : word[7:0];
  assign ext    = {{(DATA_W-8){sgn & sel[7]}}, sel};
  assign merged = lane ? {wbyte, word[7:0]} : {word[DATA_W-1:8], wbyte};
endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage controller in front of the word-only dataMemory: word/byte loads,
// word stores and byte stores via read-modify-write, with range/alignment checks.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error,
  output logic [15:0]       mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_write_en,
  output logic              mem_read_en
);
  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_WORDS);

  state_t            state;
  logic [ADDR_W-2:0] idx_q;
  logic              wr_q, size_q, sgn_q, lane_q;
  logic [7:0]        wbyte_q;
  logic              req_err;
  logic [DATA_W-1:0] ext_w, merged_w;

  assign req_err = ({1'b0, req_addr[ADDR_W-1:1]} >= MEM_LIMIT) ||
                   (req_size == SIZE_WORD && req_addr[0]);

  // Enables and address decode from state so a reset drops them immediately.
  assign req_ready    = (state == IDLE);
  assign resp_valid   = (state == RESP);
  assign mem_read_en  = (state == RD);
  assign mem_write_en = (state == WR);
  assign mem_address  = (state inside {RD, RD_WAIT, WR}) ? 16'(idx_q) : 16'h0;

  byte_lane_merge #(.DATA_W(DATA_W)) u_merge (
    .word   (mem_rdata),
    .lane   (lane_q),
    .sgn    (sgn_q),
    .wbyte  (wbyte_q),
    .ext    (ext_w),
    .merged (merged_w)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      idx_q      <= '0;
      wr_q       <= 1'b0;
      size_q     <= SIZE_WORD;
      sgn_q      <= 1'b0;
      lane_q     <= 1'b0;
      wbyte_q    <= '0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          idx_q      <= req_addr[ADDR_W-1:1];
          wr_q       <= req_write;
          size_q     <= req_size;
          sgn_q      <= req_signed;
          lane_q     <= req_addr[0];
          wbyte_q    <= req_wdata[7:0];
          resp_rdata <= '0;
          resp_error <= req_err;
          if (req_err)
            state <= RESP;
          else if (req_write && req_size == SIZE_WORD) begin
            mem_wdata <= req_wdata;
            state     <= WR;
          end else
            state <= RD;
        end
        RD:      state <= RD_WAIT;
        RD_WAIT: if (wr_q) begin
          mem_wdata <= merged_w;
          state     <= WR;
        end else begin
          resp_rdata <= (size_q == SIZE_BYTE) ? ext_w : mem_rdata;
          state      <= RESP;
        end
        WR:      state <= RESP;
        RESP:    if (resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
